// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package register_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    // Address width for a given depth; a depth of 2 still needs one bit.
    function automatic int calc_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/register_file_sweep.sv
// Sweep-clear engine: walks the pointer across every entry, one per cycle.
module register_file_sweep
    import register_file_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    output logic          busy,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    sweep_state_e  state_r;
    logic [AW-1:0] ptr_r;
    logic          busy_r;

    // Sweep state, pointer and busy flag; clear during a sweep is not queued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            ptr_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear) begin
                        state_r <= SWEEP;
                        ptr_r   <= {AW{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        ptr_r   <= {AW{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (ptr_r == LAST_ADDR) begin
                        state_r <= IDLE;
                        ptr_r   <= {AW{1'b0}};
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= SWEEP;
                        ptr_r   <= ptr_r + 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ptr_r   <= {AW{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign sweep_we   = busy_r;
    assign sweep_addr = ptr_r;

endmodule

// File: rtl/register_file.sv
// Register file with one write port, two registered read ports with
// write-first bypass, and a sequential sweep clear.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter bit ZERO_REG0 = 1'b0,
    localparam int AW       = calc_aw(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    output logic             busy,
    input  logic             load,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b
);

    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             busy_s;
    logic             sweep_we_s;
    logic [AW-1:0]    sweep_addr_s;
    logic             wr_en_s;

    register_file_sweep #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sweep (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .busy       (busy_s),
        .sweep_we   (sweep_we_s),
        .sweep_addr (sweep_addr_s)
    );

    assign busy = busy_s;

    // An address is live when it is in range and not the hard-wired zero entry.
    function automatic logic addr_live(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT) && !(ZERO_REG0 && (addr == {AW{1'b0}}));
    endfunction

    // Clear wins over load on the accepting edge; busy blocks loads entirely.
    assign wr_en_s = load && !busy_s && !clear && addr_live(waddr);

    function automatic logic [WIDTH-1:0] read_value(input logic [AW-1:0] addr);
        if (!addr_live(addr)) begin
            return {WIDTH{1'b0}};
        end else if (sweep_we_s && (sweep_addr_s == addr)) begin
            return {WIDTH{1'b0}};
        end else if (wr_en_s && (waddr == addr)) begin
            return data_in;
        end else begin
            return mem_r[addr];
        end
    endfunction

    // Storage array: sweep zeroing and load writes are mutually exclusive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (sweep_we_s) begin
            mem_r[sweep_addr_s] <= {WIDTH{1'b0}};
        end else if (wr_en_s) begin
            mem_r[waddr] <= data_in;
        end
    end

    // Registered read ports with same-edge write bypass.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out_a <= {WIDTH{1'b0}};
            data_out_b <= {WIDTH{1'b0}};
        end else begin
            data_out_a <= read_value(raddr_a);
            data_out_b <= read_value(raddr_b);
        end
    end

endmodule
